operand_mux_reg: RTL and testbench

Registered, parametrised N-way operand selector for the datapath's ALU source paths. It generalises the fixed three-input ALU-A source mux (PC / A / MDR) to WIDTH-bit operands and NUM_IN sources. It adds a one-stage output register with a valid/ready handshake so operand selection can be pipelined ahead of the ALU. Out-of-range selects are detected and flagged instead of producing undefined data.

---
 rtl/operand_mux_reg.sv | 69 ++++++
 tb/tb_operand_mux_reg.sv | 138 +++++++++++++
 2 files changed

// File: rtl/operand_mux_reg.sv
// Registered NUM_IN-way operand selector with valid/ready output stage.
// Optional OPMUX_STICKY_ERR_EN: sel_err latches on any out-of-range accept.
module operand_mux_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic [SEL_W-1:0]        last_sel,
    output logic                    sel_err
);

    logic             accept;
    logic             drain;
    logic             sel_ok;
    logic [WIDTH-1:0] pick;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign sel_ok   = 32'(sel) < NUM_IN;

    // Out-of-range selects match no slice and fall through to zero.
    always_comb begin
        pick = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                pick = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            last_sel  <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                data_out  <= pick;
                last_sel  <= sel;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
`ifdef OPMUX_STICKY_ERR_EN
            if (accept && !sel_ok) begin
                sel_err <= 1'b1;
            end
`else
            if (accept) begin
                sel_err <= !sel_ok;
            end else if (drain) begin
                sel_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_operand_mux_reg.sv
// Directed vector bench for operand_mux_reg (WIDTH=32, NUM_IN=3).
module tb_operand_mux_reg;

    localparam int W = 32;
    localparam int N = 3;
`ifdef OPMUX_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    sel;
    logic [N*W-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic [1:0]    last_sel;
    logic          sel_err;

    operand_mux_reg #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .last_sel(last_sel),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           iv;
        logic           ordy;
        logic [1:0]     s;
        logic [N*W-1:0] din;
        logic           eir;
        logic           eov;
        logic [W-1:0]   edo;
        logic [1:0]     els;
        logic           eerr;
    } vec_t;

    vec_t vt[17];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy,
                                input logic [1:0] s, input logic [W-1:0] mdr,
                                input logic [W-1:0] a, input logic [W-1:0] pc,
                                input logic eir, input logic eov,
                                input logic [W-1:0] edo, input logic [1:0] els,
                                input logic eerr);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.s = s; v.din = {mdr, a, pc};
        v.eir = eir; v.eov = eov; v.edo = edo; v.els = els; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(1,1,0, 0,0,5,                 1,1,32'h5,0,0);
        vt[1]  = mk(1,1,1, 0,5,0,                 1,1,32'h5,1,0);
        vt[2]  = mk(1,1,2, 5,0,0,                 1,1,32'h5,2,0);
        vt[3]  = mk(1,1,1, 0,32'hDEADBEEF,0,      1,1,32'hDEADBEEF,1,0);
        vt[4]  = mk(1,0,2, 32'h111,32'h222,32'h333, 0,1,32'hDEADBEEF,1,0);
        vt[5]  = mk(1,0,0, 32'h444,32'h555,32'h666, 0,1,32'hDEADBEEF,1,0);
        vt[6]  = mk(1,0,1, 32'h777,32'h888,32'h999, 0,1,32'hDEADBEEF,1,0);
        vt[7]  = mk(0,1,0, 0,0,0,                 1,0,32'hDEADBEEF,1,0);
        vt[8]  = mk(1,1,3, 1,2,3,                 1,1,32'h0,3,1);
        vt[9]  = mk(1,1,0, 0,0,32'h42,            1,1,32'h42,0,STICKY);
        vt[10] = mk(1,1,2, 32'h1234,0,0,          1,1,32'h1234,2,STICKY);
        vt[11] = mk(0,0,0, 0,0,0,                 0,1,32'h1234,2,STICKY);
        vt[12] = mk(1,0,3, 7,7,7,                 0,1,32'h1234,2,STICKY);
        vt[13] = mk(0,1,0, 0,0,0,                 1,0,32'h1234,2,STICKY);
        vt[14] = mk(1,0,3, 9,9,9,                 1,1,32'h0,3,1);
        vt[15] = mk(0,1,0, 0,0,0,                 1,0,32'h0,3,STICKY);
        vt[16] = mk(0,0,1, 0,32'h55,0,            1,0,32'h0,3,STICKY);

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_data_out",  data_out,       32'h0);
        check("rst_sel_err",   32'(sel_err),   32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = vt[i].iv; out_ready = vt[i].ordy;
            sel = vt[i].s; data_in = vt[i].din;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].eir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].eov));
            check($sformatf("v%0d_data_out", i),  data_out,       vt[i].edo);
            check($sformatf("v%0d_last_sel", i),  32'(last_sel),  32'(vt[i].els));
            check($sformatf("v%0d_sel_err", i),   32'(sel_err),   32'(vt[i].eerr));
        end

        // Reset while a transfer is held under backpressure.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; sel = 2'd1;
        data_in = {32'h0, 32'h77, 32'h0};
        @(posedge clk);
        #1;
        check("mid_hold_valid", 32'(out_valid), 32'h1);
        check("mid_hold_data",  data_out,       32'h77);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid",   32'(out_valid), 32'h0);
        check("mid_rst_data",    data_out,       32'h0);
        check("mid_rst_last",    32'(last_sel),  32'h0);
        check("mid_rst_sel_err", 32'(sel_err),   32'h0);
        check("mid_rst_ready",   32'(in_ready),  32'h1);
        @(negedge clk);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
